// File: rtl/carga_frames_me_pkg.sv
// Shared constants for the motion-estimation frame loader: default widths,
// frame size, FSM state encoding and the saturating frame-counter helper.
package carga_frames_me_pkg;

  // Address MSB index and derived widths used as module defaults
  localparam int MSBI               = 13;
  localparam int ADDR_W_DEF         = MSBI + 1;
  localparam int PIX_W_DEF          = 9;
  localparam int FRAME_PIXELS_DEF   = 8192;

  // Loader FSM encoding (kept as plain constants for compatibility with older blocks)
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD       = 3'd1;
  localparam logic [2:0] DRAIN      = 3'd2;
  localparam logic [2:0] START      = 3'd3;
  localparam logic [2:0] SEARCH     = 3'd4;

  // Completed-frame counter: counts 0,1,2,3 and then sticks at 3
  function automatic logic [1:0] sat_inc2(input logic [1:0] value);
    logic [1:0] result;
    if (value == 2'd3) begin
      result = 2'd3;
    end else begin
      result = value + 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/carga_copy_pipe.sv
// One-stage copy pipe. An accepted pixel and its address are registered; in
// the following cycle the act RAM read data for that address (the previous
// frame's pixel) is written to the ref RAM while the new pixel is written to
// the act RAM at the same address. All outputs are zero when nothing is pending.
module carga_copy_pipe
  import carga_frames_me_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [PIX_W-1:0]  load_pix,
  input  logic [PIX_W-1:0]  act_rd_data,
  output logic [ADDR_W-1:0] act_wr_addr,
  output logic [PIX_W-1:0]  act_wr_data,
  output logic              act_wr_en,
  output logic [ADDR_W-1:0] ref_wr_addr,
  output logic [PIX_W-1:0]  ref_wr_data,
  output logic              ref_wr_en
);

  logic              pend_r;
  logic [ADDR_W-1:0] addr_r;
  logic [PIX_W-1:0]  pix_r;
  logic [PIX_W-1:0]  ref_data_s;

  // Capture the accepted pixel/address; clear everything when no pixel arrives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
      pix_r  <= {PIX_W{1'b0}};
    end else if (load) begin
      pend_r <= 1'b1;
      addr_r <= load_addr;
      pix_r  <= load_pix;
    end else begin
      pend_r <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
      pix_r  <= {PIX_W{1'b0}};
    end
  end

  // Old act contents only become ref data while a write pair is pending
  always_comb begin
    ref_data_s = {PIX_W{1'b0}};
    if (pend_r) begin
      ref_data_s = act_rd_data;
    end else begin
      ref_data_s = {PIX_W{1'b0}};
    end
  end

  assign act_wr_en   = pend_r;
  assign act_wr_addr = addr_r;
  assign act_wr_data = pix_r;
  assign ref_wr_en   = pend_r;
  assign ref_wr_addr = addr_r;
  assign ref_wr_data = ref_data_s;

endmodule

// File: rtl/carga_frames_me.sv
// Frame loader in front of the motion-estimation search block. Streams one
// frame of pixels into the act RAM while moving the previous act frame into
// the ref RAM, then hands the act RAM read port to the search block and
// starts it, holding off new pixels until the search reports finish.
module carga_frames_me
  import carga_frames_me_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int PIX_W        = PIX_W_DEF,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic              act_sel,
  output logic [ADDR_W-1:0] act_rd_addr,
  input  logic [PIX_W-1:0]  act_rd_data,
  output logic [ADDR_W-1:0] act_wr_addr,
  output logic [PIX_W-1:0]  act_wr_data,
  output logic              act_wr_en,
  output logic [ADDR_W-1:0] ref_wr_addr,
  output logic [PIX_W-1:0]  ref_wr_data,
  output logic              ref_wr_en,
  output logic              me_start,
  input  logic              me_idle,
  input  logic              me_finish,
  output logic [1:0]        cont_img,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [1:0]        cont_img_r;
  logic              me_start_r;
  logic              frame_err_r;

  logic              pix_ready_s;
  logic              act_sel_s;
  logic              accept_s;
  logic              load_s;
  logic [ADDR_W-1:0] load_addr_s;
  logic              mid_sof_s;
  logic              last_s;
  logic [ADDR_W-1:0] cnt_next_s;

  // Handshake and RAM-port ownership decoded straight from the state register
  always_comb begin
    pix_ready_s = 1'b0;
    act_sel_s   = 1'b0;
    case (state_r)
      IDLE: begin
        pix_ready_s = 1'b1;
        act_sel_s   = 1'b1;
      end
      LOAD: begin
        pix_ready_s = 1'b1;
        act_sel_s   = 1'b1;
      end
      DRAIN: begin
        pix_ready_s = 1'b0;
        act_sel_s   = 1'b1;
      end
      default: begin
        pix_ready_s = 1'b0;
        act_sel_s   = 1'b0;
      end
    endcase
  end

  assign accept_s = pix_valid & pix_ready_s;

  // Decide whether the accepted pixel is stored and at which address; a sof
  // always forces address 0, inside a frame it also flags a framing error
  always_comb begin
    load_s      = 1'b0;
    load_addr_s = cnt_r;
    mid_sof_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && pix_sof) begin
          load_s      = 1'b1;
          load_addr_s = ADDR_ZERO;
        end else begin
          load_s      = 1'b0;
          load_addr_s = cnt_r;
        end
      end
      LOAD: begin
        if (accept_s) begin
          load_s = 1'b1;
          if (pix_sof) begin
            load_addr_s = ADDR_ZERO;
            mid_sof_s   = 1'b1;
          end else begin
            load_addr_s = cnt_r;
            mid_sof_s   = 1'b0;
          end
        end else begin
          load_s      = 1'b0;
          load_addr_s = cnt_r;
        end
      end
      default: begin
        load_s      = 1'b0;
        load_addr_s = cnt_r;
        mid_sof_s   = 1'b0;
      end
    endcase
  end

  // Address after the current pixel, wrapping at the end of the frame
  always_comb begin
    last_s     = 1'b0;
    cnt_next_s = ADDR_ZERO;
    if (load_s && (load_addr_s == LAST_ADDR)) begin
      last_s     = 1'b1;
      cnt_next_s = ADDR_ZERO;
    end else begin
      last_s     = 1'b0;
      cnt_next_s = load_addr_s + ADDR_ONE;
    end
  end

  // Loader FSM, address counter, frame counter and the pulse outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= ADDR_ZERO;
      cont_img_r  <= 2'd0;
      me_start_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      me_start_r  <= 1'b0;
      frame_err_r <= mid_sof_s;
      case (state_r)
        IDLE: begin
          if (load_s) begin
            cnt_r   <= cnt_next_s;
            state_r <= last_s ? DRAIN : LOAD;
          end else begin
            cnt_r   <= ADDR_ZERO;
          end
        end
        LOAD: begin
          if (load_s) begin
            cnt_r <= cnt_next_s;
            if (last_s) begin
              state_r <= DRAIN;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        DRAIN: begin
          // The first frame has no meaningful reference, so there is nothing to search
          cont_img_r <= sat_inc2(cont_img_r);
          cnt_r      <= ADDR_ZERO;
          if (cont_img_r == 2'd0) begin
            state_r <= IDLE;
          end else begin
            state_r <= START;
          end
        end
        START: begin
          if (me_idle) begin
            me_start_r <= 1'b1;
            state_r    <= SEARCH;
          end else begin
            state_r    <= START;
          end
        end
        SEARCH: begin
          // A finish arriving together with our own start pulse is stale
          if (me_finish && !me_start_r) begin
            state_r <= IDLE;
          end else begin
            state_r <= SEARCH;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= ADDR_ZERO;
        end
      endcase
    end
  end

  carga_copy_pipe #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_copy_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load_s),
    .load_addr   (load_addr_s),
    .load_pix    (pix_data),
    .act_rd_data (act_rd_data),
    .act_wr_addr (act_wr_addr),
    .act_wr_data (act_wr_data),
    .act_wr_en   (act_wr_en),
    .ref_wr_addr (ref_wr_addr),
    .ref_wr_data (ref_wr_data),
    .ref_wr_en   (ref_wr_en)
  );

  assign pix_ready   = pix_ready_s;
  assign act_sel     = act_sel_s;
  assign act_rd_addr = load_addr_s;
  assign me_start    = me_start_r;
  assign frame_err   = frame_err_r;
  assign cont_img    = cont_img_r;

endmodule

// File: tb/tb_carga_frames_me.sv
// Bench for carga_frames_me with a 16-pixel frame and 1-cycle-read RAM models.
// The driver pushes the expected write pair for every stored pixel; a monitor
// pops and compares each write pair as the DUT presents it.
module tb_carga_frames_me;

  localparam int FP = 16;
  localparam int AW = 14;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_ready;
  logic          act_sel;
  logic [AW-1:0] act_rd_addr;
  logic [PW-1:0] act_rd_data;
  logic [AW-1:0] act_wr_addr;
  logic [PW-1:0] act_wr_data;
  logic          act_wr_en;
  logic [AW-1:0] ref_wr_addr;
  logic [PW-1:0] ref_wr_data;
  logic          ref_wr_en;
  logic          me_start;
  logic          me_idle;
  logic          me_finish;
  logic [1:0]    cont_img;
  logic          frame_err;

  always #5 clk = ~clk;

  carga_frames_me #(.ADDR_W(AW), .PIX_W(PW), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .reset_n(reset_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .act_sel(act_sel),
    .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .act_wr_addr(act_wr_addr), .act_wr_data(act_wr_data), .act_wr_en(act_wr_en),
    .ref_wr_addr(ref_wr_addr), .ref_wr_data(ref_wr_data), .ref_wr_en(ref_wr_en),
    .me_start(me_start), .me_idle(me_idle), .me_finish(me_finish),
    .cont_img(cont_img), .frame_err(frame_err)
  );

  // RAM models: registered read (search side reads address 0 when it owns the port)
  logic [PW-1:0] act_mem [FP];
  logic [PW-1:0] ref_mem [FP];
  logic          mem_clr;
  logic [AW-1:0] rd_mux;
  assign rd_mux = act_sel ? act_rd_addr : '0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < FP; i++) begin
        act_mem[i] <= '0;
        ref_mem[i] <= '0;
      end
      act_rd_data <= '0;
    end else begin
      act_rd_data <= act_mem[rd_mux[3:0]];
      if (act_wr_en) act_mem[act_wr_addr[3:0]] <= act_wr_data;
      if (ref_wr_en) ref_mem[ref_wr_addr[3:0]] <= ref_wr_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int act_d; int ref_d; int cyc;} exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int ms_count = 0;
  int ms_cyc = 0;
  int fe_count = 0;

  // Bench model of RAM contents and frame addressing
  int m_act [FP];
  int m_ref [FP];
  int m_addr = 0;
  bit in_frame = 1'b0;
  int last_acc = 0;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Record an accepted pixel: push the write pair it must produce one cycle later
  task automatic model_accept(input int d, input bit sof, input int c);
    int a;
    if (sof) begin
      a = 0;
      in_frame = 1'b1;
    end else if (in_frame) begin
      a = m_addr;
    end else begin
      return;
    end
    exp_q.push_back('{addr: a, act_d: d, ref_d: m_act[a], cyc: c});
    m_ref[a] = m_act[a];
    m_act[a] = d;
    last_acc = c;
    if (a == FP - 1) begin
      in_frame = 1'b0;
      m_addr = 0;
    end else begin
      m_addr = a + 1;
    end
  endtask

  // Present one pixel and hold it until accepted (bounded wait)
  task automatic drive_pix(input int d, input bit sof);
    int waitn = 0;
    pix_data  = PW'(d);
    pix_sof   = sof;
    pix_valid = 1'b1;
    while (!pix_ready && waitn < 60) begin
      @(posedge clk); #1;
      waitn++;
    end
    if (!pix_ready) begin
      tests++;
      fails++;
      $display("FAIL pix_ready_timeout: got 0, expected 1 within 60 cycles");
    end else begin
      model_accept(d, sof, cyc + 1);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  int gap_tbl [FP] = '{0, 2, 0, 1, 3, 0, 0, 2, 1, 0, 3, 0, 1, 1, 0, 2};

  task automatic send_frame(input int base, input bit gaps);
    for (int i = 0; i < FP; i++) begin
      if (gaps) repeat (gap_tbl[i]) begin @(posedge clk); #1; end
      drive_pix(base + i, i == 0);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic finish_search();
    me_finish = 1'b1;
    @(posedge clk); #1;
    me_finish = 1'b0;
  endtask

  task automatic compare_rams(input string tag);
    int bad_act = 0;
    int bad_ref = 0;
    for (int i = 0; i < FP; i++) begin
      if (int'(act_mem[i]) != m_act[i]) bad_act++;
      if (int'(ref_mem[i]) != m_ref[i]) bad_ref++;
    end
    check({tag, "_act_ram_mismatches"}, bad_act, 0);
    check({tag, "_ref_ram_mismatches"}, bad_ref, 0);
  endtask

  // Monitor: every write pair is checked against the oldest expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (act_wr_en || ref_wr_en) begin
        wr_count++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d at cyc %0d, expected no write",
                   act_wr_addr, act_wr_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (!(act_wr_en && ref_wr_en) || int'(act_wr_addr) != e.addr ||
              int'(ref_wr_addr) != e.addr || int'(act_wr_data) != e.act_d ||
              int'(ref_wr_data) != e.ref_d || cyc != e.cyc) begin
            fails++;
            $display("FAIL write_pair: got en=%b/%b addr=%0d/%0d act=%0d ref=%0d cyc=%0d, expected addr=%0d act=%0d ref=%0d cyc=%0d",
                     act_wr_en, ref_wr_en, act_wr_addr, ref_wr_addr, act_wr_data,
                     ref_wr_data, cyc, e.addr, e.act_d, e.ref_d, e.cyc);
          end
        end
      end
      if (me_start) begin
        ms_count++;
        ms_cyc = cyc;
      end
      if (frame_err) fe_count++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ms0, fe0, wc0, l;
    reset_n = 1'b0; pix_data = '0; pix_valid = 1'b0; pix_sof = 1'b0;
    me_idle = 1'b1; me_finish = 1'b0; mem_clr = 1'b1;
    for (int i = 0; i < FP; i++) begin m_act[i] = 0; m_ref[i] = 0; end
    wait_cyc(3);
    mem_clr = 1'b0;

    // Reset state
    check("rst_pix_ready", pix_ready, 1);
    check("rst_act_sel", act_sel, 1);
    check("rst_cont_img", cont_img, 0);
    check("rst_wr_en", {act_wr_en, ref_wr_en}, 0);
    check("rst_wr_addr", act_wr_addr, 0);
    check("rst_me_start", me_start, 0);
    check("rst_frame_err", frame_err, 0);
    reset_n = 1'b1;
    wait_cyc(1);

    // Test 1: first frame, no search
    send_frame(0, 1'b0);
    wait_cyc(4);
    check("t1_cont_img", cont_img, 1);
    check("t1_no_me_start", ms_count, 0);
    check("t1_back_idle_ready", pix_ready, 1);
    check("t1_ref_writes", wr_count, 16);
    for (int i = 0; i < FP; i++) check("t1_act_ram", act_mem[i], i);

    // Test 2: second frame, search start/finish handshake
    ms0 = ms_count;
    send_frame(100, 1'b0);
    l = last_acc;
    wait_cyc(4);
    check("t2_cont_img", cont_img, 2);
    check("t2_me_start_once", ms_count, ms0 + 1);
    check("t2_me_start_cycle", ms_cyc, l + 2);
    check("t2_ready_held", pix_ready, 0);
    check("t2_act_sel_search", act_sel, 0);
    for (int i = 0; i < FP; i++) begin
      check("t2_ref_ram", ref_mem[i], i);
      check("t2_act_ram", act_mem[i], 100 + i);
    end
    wait_cyc(3);
    check("t2_ready_before_finish", pix_ready, 0);
    finish_search();
    check("t2_ready_after_finish", pix_ready, 1);

    // Test 4: sof at pixel 5 restarts the frame
    fe0 = fe_count;
    for (int i = 0; i < 5; i++) drive_pix(50 + i, i == 0);
    for (int i = 0; i < FP; i++) begin
      drive_pix(60 + i, i == 0);
      if (i == 8) begin
        check("t4_frame_err_once", fe_count, fe0 + 1);
        check("t4_cont_img_unchanged", cont_img, 2);
      end
    end
    wait_cyc(4);
    check("t4_cont_img_done", cont_img, 3);
    check("t4_frame_err_total", fe_count, fe0 + 1);
    compare_rams("t4");
    finish_search();

    // Test 3: frame with pix_valid gaps, cont_img saturates
    send_frame(200, 1'b1);
    wait_cyc(4);
    check("t3_cont_img_sat", cont_img, 3);
    compare_rams("t3");
    finish_search();

    // Test 6: me_idle low for 10 extra cycles delays me_start by 10
    ms0 = ms_count;
    me_idle = 1'b0;
    send_frame(300, 1'b0);
    l = last_acc;
    wait_cyc(11);
    check("t6_no_start_while_busy", ms_count, ms0);
    me_idle = 1'b1;
    wait_cyc(3);
    check("t6_me_start_once", ms_count, ms0 + 1);
    check("t6_me_start_delayed", ms_cyc, l + 12);
    finish_search();

    // Test 5: reset in the middle of a frame at address 7
    for (int i = 0; i < 7; i++) drive_pix(400 + i, i == 0);
    pix_data = PW'(407); pix_valid = 1'b1;
    wait_cyc(1);
    pix_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t5_wr_en_drop", {act_wr_en, ref_wr_en}, 0);
    check("t5_cont_img_cleared", cont_img, 0);
    in_frame = 1'b0;
    m_addr = 0;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(1);
    wc0 = wr_count;
    for (int i = 0; i < 3; i++) drive_pix(85 + i, 1'b0);
    wait_cyc(3);
    check("t5_nonsof_dropped", wr_count, wc0);
    ms0 = ms_count;
    send_frame(450, 1'b0);
    wait_cyc(4);
    check("t5_cont_img_first", cont_img, 1);
    check("t5_no_me_start", ms_count, ms0);
    check("t5_idle_ready", pix_ready, 1);
    compare_rams("t5");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
